escalonador_processos: RTL and testbench
========================================

ESCALONADOR_PROCESSOS -- requirements
Module: escalonador_processos

Interface
REQ-001 SHALL have parameter N_PROC, default 4: number of user process partitions (2..8).
REQ-002 SHALL have parameter ID_W, default 3: width of id_proc; 2^ID_W > N_PROC.
REQ-003 SHALL have parameter QUANTUM, default 16: time slice in enabled CPU cycles (>=2).
REQ-004 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high.
REQ-006 SHALL have port inicia  input  1: level; SO requests start of scheduling.
REQ-007 SHALL have port proc_pronto  input  N_PROC: bit i=1 means partition i holds a loaded program.
REQ-008 SHALL have port HALT  input  1: running process executed halt.
REQ-009 SHALL have port WAIT  input  1: CPU stalled on input; READY  input  1: user confirmation.
REQ-010 SHALL have port ctx_ok  input  1: context save/restore engine done, 1-cycle pulse.
REQ-011 SHALL have port id_proc  output  ID_W: partition selector (0 = SO, i+1 = process i).
REQ-012 SHALL have ports Sel_BIOS, bloq_cpu, salva_ctx, restaura_ctx, troca  output  1 each.
REQ-013 SHALL have ports concluidos  output  N_PROC: finished-process mask; estado  output  3: FSM state.

Function
REQ-014 SHALL implement states OCIOSO=0, SELECIONA=1, RESTAURA=2, EXECUTA=3, SALVA=4; all outputs registered.
REQ-015 OCIOSO: Sel_BIOS=1, bloq_cpu=0, id_proc=0; go SELECIONA when inicia=1 and candidates (proc_pronto & ~concluidos) nonzero.
REQ-016 SELECIONA (exactly 1 cycle): pick first candidate scanning from (ultimo+1) mod N_PROC upward with wrap; ultimo resets to N_PROC-1 so first pick is lowest index.
REQ-017 SELECIONA with zero candidates SHALL return to OCIOSO, id_proc=0, Sel_BIOS=1.
REQ-018 SELECIONA->RESTAURA SHALL load id_proc=pick+1, ultimo=pick, and pulse troca for exactly one cycle.
REQ-019 RESTAURA: restaura_ctx=1, bloq_cpu=1, Sel_BIOS=0; stay until ctx_ok=1, then EXECUTA with quantum counter = QUANTUM-1.
REQ-020 EXECUTA: bloq_cpu=0, Sel_BIOS=0; counter decrements once per cycle when CPU enabled (WAIT=0 or READY=1); frozen otherwise.
REQ-021 EXECUTA with HALT=1: set concluidos[id_proc-1], go SELECIONA directly (no save).
REQ-022 Quantum expiry = counter==0 on an enabled cycle; handled per Configuration.
REQ-023 HALT and quantum expiry in the same cycle: HALT wins.
REQ-024 SALVA: salva_ctx=1, bloq_cpu=1; stay until ctx_ok=1, then SELECIONA.
REQ-025 Single remaining candidate SHALL be re-selected with full SALVA/RESTAURA sequence.
REQ-026 ctx_ok outside RESTAURA/SALVA, and HALT outside EXECUTA, SHALL be ignored.
REQ-027 proc_pronto changes SHALL only be sampled in OCIOSO and SELECIONA.
REQ-028 All candidates finished: SELECIONA->OCIOSO; new scheduling requires reset to clear concluidos.
REQ-029 inicia deasserting after leaving OCIOSO SHALL have no effect.

Reset
REQ-030 reset=1 at a clock edge SHALL, in any state: estado=OCIOSO, id_proc=0, Sel_BIOS=1, bloq_cpu=0, salva_ctx=0, restaura_ctx=0, troca=0, concluidos=0, counter=0, ultimo=N_PROC-1.
REQ-031 reset during RESTAURA/SALVA SHALL abandon the handshake; a later ctx_ok SHALL be ignored.

Configuration
REQ-032 Macro ESCALONADOR_PREEMPCAO_EN defined: quantum expiry in EXECUTA SHALL go SALVA (preemptive round-robin).
REQ-033 Macro ESCALONADOR_PREEMPCAO_EN undefined: counter logic omitted; EXECUTA leaves only on HALT (cooperative); all else unchanged.

Verification (N_PROC=4, QUANTUM=4, macro defined unless stated)
REQ-034 proc_pronto=4'b0101, inicia=1, ctx_ok 2 cycles after each request -> id_proc 1,3,1,3...; troca one cycle per switch; EXECUTA lasts 4 cycles.
REQ-035 During EXECUTA hold WAIT=1, READY=0 for 10 cycles -> counter frozen, still EXECUTA; READY=1 resumes countdown.
REQ-036 HALT on same cycle as counter==0 for process 0 -> concluidos=4'b0001, SELECIONA next, no salva_ctx.
REQ-037 All processes halt -> OCIOSO, Sel_BIOS=1, id_proc=0, concluidos=proc_pronto.
REQ-038 reset pulsed in SALVA, ctx_ok pulsed next cycle -> outputs at reset values, stays OCIOSO while inicia=0.
REQ-039 Macro undefined, proc_pronto=4'b0011 -> process 0 runs 50 cycles with no switch until HALT, then id_proc=2.

Source files
------------

// File: rtl/escalonador_processos.sv
// escalonador_processos: round-robin process scheduler (optional preemption via ESCALONADOR_PREEMPCAO_EN)
module escalonador_processos #(
    parameter int N_PROC  = 4,
    parameter int ID_W    = 3,
    parameter int QUANTUM = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicia,
    input  logic [N_PROC-1:0] proc_pronto,
    input  logic              HALT,
    input  logic              WAIT,
    input  logic              READY,
    input  logic              ctx_ok,
    output logic [ID_W-1:0]   id_proc,
    output logic              Sel_BIOS,
    output logic              bloq_cpu,
    output logic              salva_ctx,
    output logic              restaura_ctx,
    output logic              troca,
    output logic [N_PROC-1:0] concluidos,
    output logic [2:0]        estado
);
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SELECIONA = 3'd1,
        RESTAURA  = 3'd2,
        EXECUTA   = 3'd3,
        SALVA     = 3'd4
    } estado_t;

    estado_t           state, state_n;
    logic [ID_W-1:0]   ultimo, pick, pick_hi, pick_lo;
    logic              found_hi, found_lo;
    logic [N_PROC-1:0] cand;
    logic              expira, troca_n, so_n;

    assign cand    = proc_pronto & ~concluidos;
    assign pick    = found_hi ? pick_hi : pick_lo;
    assign troca_n = state == SELECIONA && state_n == RESTAURA;
    assign so_n    = state_n == OCIOSO || state_n == SELECIONA;
    assign estado  = state;

`ifdef ESCALONADOR_PREEMPCAO_EN
    localparam int CW = $clog2(QUANTUM);
    logic [CW-1:0] cnt;
    logic          en;
    assign en     = !WAIT || READY;
    assign expira = en && cnt == '0;

    // quantum countdown, frozen while the CPU is stalled on input
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state == RESTAURA && ctx_ok)
            cnt <= CW'(QUANTUM - 1);
        else if (state == EXECUTA && en && cnt != '0)
            cnt <= cnt - CW'(1);
    end
`else
    logic unused_cpu_en;
    assign unused_cpu_en = ^{WAIT, READY};
    assign expira        = 1'b0;
`endif

    // round-robin search: lowest candidate above ultimo, else lowest candidate overall
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found_lo = 1'b1;
                pick_lo  = ID_W'(i);
                if (ID_W'(i) > ultimo) begin
                    found_hi = 1'b1;
                    pick_hi  = ID_W'(i);
                end
            end
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            OCIOSO:    state_n = (inicia && |cand) ? SELECIONA : OCIOSO;
            SELECIONA: state_n = found_lo ? RESTAURA : OCIOSO;
            RESTAURA:  state_n = ctx_ok ? EXECUTA : RESTAURA;
            EXECUTA:   state_n = HALT ? SELECIONA : (expira ? SALVA : EXECUTA);
            SALVA:     state_n = ctx_ok ? SELECIONA : SALVA;
            default:   state_n = OCIOSO;
        endcase
    end

    // state register and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= OCIOSO;
            id_proc      <= '0;
            Sel_BIOS     <= 1'b1;
            bloq_cpu     <= 1'b0;
            salva_ctx    <= 1'b0;
            restaura_ctx <= 1'b0;
            troca        <= 1'b0;
            concluidos   <= '0;
            ultimo       <= ID_W'(N_PROC - 1);
        end else begin
            state        <= state_n;
            Sel_BIOS     <= so_n;
            bloq_cpu     <= state_n == RESTAURA || state_n == SALVA;
            salva_ctx    <= state_n == SALVA;
            restaura_ctx <= state_n == RESTAURA;
            troca        <= troca_n;
            id_proc      <= troca_n ? pick + ID_W'(1) : (so_n ? '0 : id_proc);
            if (troca_n)
                ultimo <= pick;
            if (state == EXECUTA && HALT)
                concluidos <= concluidos | (N_PROC'(1) << (id_proc - ID_W'(1)));
        end
    end
endmodule

// File: tb/tb_escalonador_processos.sv
// tb_escalonador_processos: table vectors plus multi-cycle sequences for the scheduler
module tb_escalonador_processos;
    logic       clk = 0, reset = 0, inicia = 0, HALT = 0, WAIT = 0, READY = 0, ctx_ok = 0;
    logic [3:0] proc_pronto = 0;
    logic [2:0] id_proc, estado;
    logic       Sel_BIOS, bloq_cpu, salva_ctx, restaura_ctx, troca;
    logic [3:0] concluidos;

    always #5 clk = ~clk;

    escalonador_processos #(.N_PROC(4), .ID_W(3), .QUANTUM(4)) dut (
        .clk(clk), .reset(reset), .inicia(inicia), .proc_pronto(proc_pronto),
        .HALT(HALT), .WAIT(WAIT), .READY(READY), .ctx_ok(ctx_ok),
        .id_proc(id_proc), .Sel_BIOS(Sel_BIOS), .bloq_cpu(bloq_cpu),
        .salva_ctx(salva_ctx), .restaura_ctx(restaura_ctx), .troca(troca),
        .concluidos(concluidos), .estado(estado)
    );

    typedef struct {
        logic        rst, ini;
        logic [3:0]  pr;
        logic        h, w, r, ok;
        logic [14:0] exp;
    } vec_t;

    int          n_cmp = 0, n_err = 0;
    logic [14:0] sb[$];
    vec_t        tv[12];

    // expected output tuple: {estado, id_proc, Sel_BIOS, bloq_cpu, salva_ctx, restaura_ctx, troca, concluidos}
    function automatic logic [14:0] E(logic [2:0] e, logic [2:0] id, logic [4:0] f, logic [3:0] c);
        return {e, id, f, c};
    endfunction

    function automatic logic [14:0] outs();
        return {estado, id_proc, Sel_BIOS, bloq_cpu, salva_ctx, restaura_ctx, troca, concluidos};
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(vec_t v, string nm);
        reset = v.rst; inicia = v.ini; proc_pronto = v.pr;
        HALT = v.h; WAIT = v.w; READY = v.r; ctx_ok = v.ok;
        sb.push_back(v.exp);
        tick();
        cmp(nm, 32'(outs()), 32'(sb.pop_front()));
    endtask

    task automatic do_reset();
        reset = 1; inicia = 0; HALT = 0; WAIT = 0; READY = 0; ctx_ok = 0;
        tick();
        reset = 0;
    endtask

    task automatic start_run(logic [3:0] pr);
        do_reset();
        proc_pronto = pr; inicia = 1;
        tick();
        tick();
        ctx_ok = 1;
        tick();
        ctx_ok = 0;
    endtask

    initial begin
        tv[0]  = '{1, 0, 4'b0000, 0, 0, 0, 0, E(0, 0, 5'b10000, 4'b0000)};
        tv[1]  = '{0, 1, 4'b0101, 0, 0, 0, 0, E(1, 0, 5'b10000, 4'b0000)};
        tv[2]  = '{0, 1, 4'b0101, 0, 0, 0, 0, E(2, 1, 5'b01011, 4'b0000)};
        tv[3]  = '{0, 1, 4'b0101, 1, 0, 0, 0, E(2, 1, 5'b01010, 4'b0000)};
        tv[4]  = '{0, 1, 4'b0101, 0, 0, 0, 1, E(3, 1, 5'b00000, 4'b0000)};
        tv[5]  = '{0, 1, 4'b0101, 0, 1, 0, 1, E(3, 1, 5'b00000, 4'b0000)};
        tv[6]  = '{0, 1, 4'b0101, 1, 0, 0, 0, E(1, 0, 5'b10000, 4'b0001)};
        tv[7]  = '{0, 0, 4'b0101, 0, 0, 0, 0, E(2, 3, 5'b01011, 4'b0001)};
        tv[8]  = '{0, 0, 4'b0101, 0, 0, 0, 1, E(3, 3, 5'b00000, 4'b0001)};
        tv[9]  = '{0, 0, 4'b0101, 1, 0, 0, 0, E(1, 0, 5'b10000, 4'b0101)};
        tv[10] = '{0, 1, 4'b0101, 0, 0, 0, 0, E(0, 0, 5'b10000, 4'b0101)};
        tv[11] = '{0, 1, 4'b0101, 0, 0, 0, 0, E(0, 0, 5'b10000, 4'b0101)};
        for (int i = 0; i < 12; i++)
            drive(tv[i], $sformatf("vec%0d", i));

`ifdef ESCALONADOR_PREEMPCAO_EN
        begin
            int   pend, run;
            logic prev_troca;
            int   ids[$];
            int   runs[$];
            do_reset();
            proc_pronto = 4'b0101; inicia = 1;
            pend = 0; run = 0; prev_troca = 0;
            for (int c = 0; c < 80; c++) begin
                ctx_ok = (pend == 2);
                tick();
                if (ctx_ok) pend = 0;
                else if (restaura_ctx || salva_ctx) pend++;
                if (troca) ids.push_back(int'(id_proc));
                if (troca && prev_troca) cmp("troca_single", 1, 0);
                prev_troca = troca;
                if (estado == 3) run++;
                else if (run > 0) begin
                    runs.push_back(run);
                    run = 0;
                end
            end
            ctx_ok = 0;
            cmp("rr_switches", 32'(ids.size() >= 4), 1);
            cmp("rr_runs", 32'(runs.size() >= 4), 1);
            for (int k = 0; k < 4 && k < ids.size(); k++)
                cmp($sformatf("rr_id%0d", k), 32'(ids[k]), (k % 2) ? 3 : 1);
            for (int k = 0; k < 4 && k < runs.size(); k++)
                cmp($sformatf("rr_len%0d", k), 32'(runs[k]), 4);
        end
        start_run(4'b0001);
        tick();
        WAIT = 1; READY = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            cmp($sformatf("wait_frozen%0d", c), 32'(estado), 3);
        end
        READY = 1;
        tick();
        tick();
        cmp("ready_resume_exec", 32'(estado), 3);
        tick();
        cmp("ready_expire_salva", 32'(outs()), 32'(E(4, 1, 5'b01100, 4'b0000)));
        WAIT = 0; READY = 0;
        reset = 1;
        tick();
        cmp("reset_in_salva", 32'(outs()), 32'(E(0, 0, 5'b10000, 4'b0000)));
        reset = 0; inicia = 0; ctx_ok = 1;
        tick();
        ctx_ok = 0;
        cmp("late_ctx_ok", 32'(outs()), 32'(E(0, 0, 5'b10000, 4'b0000)));
        tick();
        tick();
        cmp("idle_no_inicia", 32'(outs()), 32'(E(0, 0, 5'b10000, 4'b0000)));
        start_run(4'b0011);
        tick();
        tick();
        tick();
        cmp("cnt_zero_exec", 32'(estado), 3);
        HALT = 1;
        tick();
        HALT = 0;
        cmp("halt_wins", 32'(outs()), 32'(E(1, 0, 5'b10000, 4'b0001)));
        tick();
        cmp("after_halt_next", 32'(outs()), 32'(E(2, 2, 5'b01011, 4'b0001)));
`else
        begin
            int bad;
            start_run(4'b0011);
            bad = 0;
            for (int c = 0; c < 50; c++) begin
                tick();
                if (estado != 3 || troca || id_proc != 1) bad++;
            end
            cmp("coop_no_switch", 32'(bad), 0);
            HALT = 1;
            tick();
            HALT = 0;
            cmp("coop_halt", 32'(outs()), 32'(E(1, 0, 5'b10000, 4'b0001)));
            tick();
            cmp("coop_next", 32'(outs()), 32'(E(2, 2, 5'b01011, 4'b0001)));
            reset = 1;
            tick();
            reset = 0; inicia = 0; ctx_ok = 1;
            tick();
            ctx_ok = 0;
            cmp("reset_in_restaura", 32'(outs()), 32'(E(0, 0, 5'b10000, 4'b0000)));
            tick();
            cmp("idle_no_inicia", 32'(outs()), 32'(E(0, 0, 5'b10000, 4'b0000)));
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
